shared_lkroute_scheduler: RTL



---
 rtl/shared_lkroute_scheduler_pkg.sv | 18 +
 rtl/shared_lkroute_scheduler_if.sv | 27 ++
 rtl/shared_lkroute_scheduler_rr_arbiter.sv | 39 +++
 rtl/shared_lkroute_scheduler.sv | 86 ++++++++
 4 files changed

// File: rtl/shared_lkroute_scheduler_pkg.sv
// Shared helpers for the look-ahead route scheduler: index width and
// slice offsets into P-packed buses.
package shared_lkroute_scheduler_pkg;

  // Index width for n items, never below one bit.
  function automatic int lk_log2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // LSB position of slice i in a bus packed w bits per port.
  function automatic int lk_slice_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/shared_lkroute_scheduler_if.sv
// Requester-side and routing-unit-side signals of the scheduler.
interface shared_lkroute_scheduler_if #(
  parameter int P     = 5,
  parameter int EAw   = 3,
  parameter int DSTPw = 4
);
  logic [P-1:0]       req;
  logic [P*EAw-1:0]   dest_e_addr_all;
  logic [P*DSTPw-1:0] destport_all;
  logic [EAw-1:0]     rt_dest_e_addr;
  logic [DSTPw-1:0]   rt_destport;
  logic               rt_valid;
  logic [DSTPw-1:0]   rt_lkdestport;
  logic [P-1:0]       ack;
  logic [P*DSTPw-1:0] lkdestport_all;
  logic [P-1:0]       busy;

  modport slave (
    input  req, dest_e_addr_all, destport_all, rt_lkdestport,
    output rt_dest_e_addr, rt_destport, rt_valid, ack, lkdestport_all, busy
  );

  modport master (
    output req, dest_e_addr_all, destport_all, rt_lkdestport,
    input  rt_dest_e_addr, rt_destport, rt_valid, ack, lkdestport_all, busy
  );
endinterface

// File: rtl/shared_lkroute_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past
// the winner on every grant and holds otherwise.
module shared_lkroute_scheduler_rr_arbiter #(
  parameter int P  = 5,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [P-1:0]  req,
  output logic [P-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);
  logic [PW-1:0] ptr;

  // First requester at or after the pointer, wrapping modulo P.
  always_comb begin
    int c;
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < P; k++) begin
      c = int'(ptr) + k;
      if (c >= P) c = c - P;
      if (!grant_vld && req[c]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(c);
        grant[c]  = 1'b1;
      end
    end
  end

  // Pointer advances to the port after the winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ptr <= '0;
    else if (grant_vld) ptr <= (int'(grant_idx) == P - 1) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/shared_lkroute_scheduler.sv
// Time-multiplexes one look-ahead routing unit among P input ports:
// arbitrates, issues, tracks tags through the unit latency, and returns
// each result to its port with a one-cycle ack.
module shared_lkroute_scheduler
  import shared_lkroute_scheduler_pkg::*;
#(
  parameter int P             = 5,
  parameter int EAw           = 3,
  parameter int DSTPw         = 4,
  parameter int ROUTE_LATENCY = 0
) (
  input logic                     clk,
  input logic                     reset,
  shared_lkroute_scheduler_if.slave bus
);
  localparam int PW = lk_log2(P);
  localparam int L  = ROUTE_LATENCY;

  logic [P-1:0]             busy_q, ack_q, elig, grant;
  logic [P-1:0][DSTPw-1:0]  lk_q;
  logic [PW-1:0]            grant_idx;
  logic                     grant_vld;
  logic [L:0]               vld_pipe;
  logic [PW-1:0]            idx_pipe [L:0];
  logic                     cap_vld;
  logic [PW-1:0]            cap_idx;

  assign elig = bus.req & ~busy_q;

  shared_lkroute_scheduler_rr_arbiter #(.P(P), .PW(PW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (elig),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Drive the shared unit from the granted port's slice; zero when idle.
  always_comb begin
    bus.rt_valid       = grant_vld;
    bus.rt_dest_e_addr = '0;
    bus.rt_destport    = '0;
    if (grant_vld) begin
      bus.rt_dest_e_addr = bus.dest_e_addr_all[lk_slice_lo(int'(grant_idx), EAw) +: EAw];
      bus.rt_destport    = bus.destport_all[lk_slice_lo(int'(grant_idx), DSTPw) +: DSTPw];
    end
  end

  // Stage 0 is the issue tag; stages 1..L mirror the unit's registers.
  assign vld_pipe[0] = grant_vld;
  assign idx_pipe[0] = grant_idx;

  for (genvar s = 1; s <= L; s++) begin : g_tag
    // Tag shift register stage s.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_pipe[s] <= 1'b0;
        idx_pipe[s] <= '0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  assign cap_vld = vld_pipe[L];
  assign cap_idx = idx_pipe[L];

  // Capture results, pulse ack, and hold busy from issue through the ack cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q  <= '0;
      busy_q <= '0;
      lk_q   <= '0;
    end else begin
      ack_q  <= cap_vld ? (P'(1) << cap_idx) : '0;
      busy_q <= (busy_q | grant) & ~ack_q;
      if (cap_vld) lk_q[cap_idx] <= bus.rt_lkdestport;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.busy           = busy_q;
  assign bus.lkdestport_all = lk_q;
endmodule
